// File: rtl/interconn_pkg.sv
// -----------------------------------------------------------------------------
// interconn_pkg
// Definitions shared by the priority interconnect and the per-MVU receive
// buffers.
//   N_MVU       : number of MVUs (width of the one-hot source tag)
//   W_WORD      : data word width
//   BADDR_W     : MVU data-memory address width
//   irb_entry_t : one buffered word {src one-hot, addr, word}
//   clog2()     : ceiling log2, usable in constant expressions
// -----------------------------------------------------------------------------
package interconn_pkg;

  localparam int N_MVU   = 8;
  localparam int W_WORD  = 64;
  localparam int BADDR_W = 15;

  typedef struct packed {
    logic [N_MVU-1:0]   src;
    logic [BADDR_W-1:0] addr;
    logic [W_WORD-1:0]  word;
  } irb_entry_t;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Circular-buffer FIFO: storage array, read/write pointers and a separate
// occupancy counter. It performs no protection of its own; the instantiating
// block decides when push/pop are legal.
// Ports:
//   clk   : clock
//   srst  : synchronous active-high reset (pointers and count to zero)
//   push  : write din at the tail this cycle
//   pop   : advance the head this cycle
//   din   : entry to write
//   dout  : current head entry (combinational view of the array)
//   cnt   : occupancy, 0..DEPTH
//   full  : cnt == DEPTH
//   empty : cnt == 0
// -----------------------------------------------------------------------------
module sync_fifo
  import interconn_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int EW    = 87
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [EW-1:0]              din,
  output logic [EW-1:0]              dout,
  output logic [clog2(DEPTH+1)-1:0]  cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH+1);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // When full, write and read pointers coincide; a same-cycle push+pop reads
  // the old head here before the edge overwrites that slot.
  assign dout  = r_mem[r_rd_ptr];
  assign cnt   = r_cnt;
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);

endmodule

// File: rtl/interconn_recv_buf.sv
// -----------------------------------------------------------------------------
// interconn_recv_buf
// Per-MVU receive buffer downstream of the priority interconnect. Every word
// delivered by the interconnect is queued and drained into the MVU
// data-memory write port on cycles where the local MVU is not using it.
// Words that arrive with no room are dropped and flagged in a sticky ovf.
//
// Optional feature, macro IRB_SRC_CNT_EN: per-source 16-bit saturating
// counters of words written to memory (src_cnt), cleared by cnt_clr.
//
// Ports:
//   clk        : clock
//   clr        : synchronous active-high reset
//   recv_from  : one-hot source MVU of the incoming word (0 is carried as-is)
//   recv_en    : incoming word valid, one pulse per word
//   recv_addr  : destination memory address
//   recv_word  : incoming data
//   mem_busy   : local MVU owns the memory write port this cycle
//   wr_en      : memory write strobe (registered)
//   wr_addr    : memory write address (held when wr_en is low)
//   wr_word    : memory write data (held when wr_en is low)
//   wr_src     : one-hot source of the word being written
//   fifo_cnt   : current occupancy
//   fifo_full  : fifo_cnt == DEPTH
//   ovf        : sticky overflow flag
//   ovf_clr    : clears ovf (a same-cycle drop wins)
//   cnt_clr    : (IRB_SRC_CNT_EN) clears all src_cnt counters
//   src_cnt    : (IRB_SRC_CNT_EN) per-source write counts
// -----------------------------------------------------------------------------
module interconn_recv_buf
  import interconn_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 64,
  parameter int BADDR = 15,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [N-1:0]               recv_from,
  input  logic                       recv_en,
  input  logic [BADDR-1:0]           recv_addr,
  input  logic [W-1:0]               recv_word,
  input  logic                       mem_busy,
  output logic                       wr_en,
  output logic [BADDR-1:0]           wr_addr,
  output logic [W-1:0]               wr_word,
  output logic [N-1:0]               wr_src,
  output logic [clog2(DEPTH+1)-1:0]  fifo_cnt,
  output logic                       fifo_full,
  output logic                       ovf,
  input  logic                       ovf_clr
`ifdef IRB_SRC_CNT_EN
  ,
  input  logic                       cnt_clr,
  output logic [N-1:0][15:0]         src_cnt
`endif
);

  localparam int EW = N + BADDR + W;

  logic [EW-1:0]               w_din;
  logic [EW-1:0]               w_head;
  logic [clog2(DEPTH+1)-1:0]   w_cnt;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_drop;

  logic                        r_wr_en;
  logic [BADDR-1:0]            r_wr_addr;
  logic [W-1:0]                r_wr_word;
  logic [N-1:0]                r_wr_src;
  logic                        r_ovf;

  assign w_din = {recv_from, recv_addr, recv_word};

  // Drain whenever there is something buffered and the port is free. A full
  // FIFO that is draining this cycle can still accept the incoming word.
  assign w_pop  = !w_empty && !mem_busy;
  assign w_push = recv_en && (!w_full || w_pop);
  assign w_drop = recv_en && !w_push;

  sync_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk   (clk),
    .srst  (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .cnt   (w_cnt),
    .full  (w_full),
    .empty (w_empty)
  );

  // Registered write port: the head is captured on the pop cycle and the
  // address/data/source hold their last values between writes.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_word <= '0;
      r_wr_src  <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_src  <= w_head[EW-1 -: N];
        r_wr_addr <= w_head[W +: BADDR];
        r_wr_word <= w_head[W-1:0];
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_word   = r_wr_word;
  assign wr_src    = r_wr_src;
  assign fifo_cnt  = w_cnt;
  assign fifo_full = w_full;
  assign ovf       = r_ovf;

`ifdef IRB_SRC_CNT_EN
  // Counters follow the registered write, so a count becomes visible the
  // cycle after its wr_en. A zero tag increments nothing.
  for (genvar gi = 0; gi < N; gi++) begin : g_src_cnt
    logic [15:0] r_src_cnt;

    always_ff @(posedge clk) begin
      if (clr || cnt_clr) begin
        r_src_cnt <= '0;
      end else if (r_wr_en && r_wr_src[gi] && (r_src_cnt != 16'hFFFF)) begin
        r_src_cnt <= r_src_cnt + 16'd1;
      end
    end

    assign src_cnt[gi] = r_src_cnt;
  end
`endif

endmodule

// File: tb/tb_interconn_recv_buf.sv
// -----------------------------------------------------------------------------
// tb_interconn_recv_buf
// Self-checking bench for interconn_recv_buf. A queue-based reference model
// tracks buffered words, the expected write port and the overflow flag.
// Define IRB_SRC_CNT_EN to also exercise the per-source counters.
// -----------------------------------------------------------------------------
module tb_interconn_recv_buf;
  import interconn_pkg::*;

  localparam int N     = N_MVU;
  localparam int W     = W_WORD;
  localparam int BADDR = BADDR_W;
  localparam int DEPTH = 8;
  localparam int CW    = clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [N-1:0]     recv_from = '0;
  logic             recv_en = 1'b0;
  logic [BADDR-1:0] recv_addr = '0;
  logic [W-1:0]     recv_word = '0;
  logic             mem_busy = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             wr_en;
  logic [BADDR-1:0] wr_addr;
  logic [W-1:0]     wr_word;
  logic [N-1:0]     wr_src;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full;
  logic             ovf;
`ifdef IRB_SRC_CNT_EN
  logic             cnt_clr = 1'b0;
  logic [N-1:0][15:0] src_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  irb_entry_t m_q[$];
  logic       m_wr_en = 1'b0;
  irb_entry_t m_wr    = '0;
  logic       m_ovf   = 1'b0;

  always #5 clk = ~clk;

  interconn_recv_buf #(
    .N     (N),
    .W     (W),
    .BADDR (BADDR),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .recv_from (recv_from),
    .recv_en   (recv_en),
    .recv_addr (recv_addr),
    .recv_word (recv_word),
    .mem_busy  (mem_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_word   (wr_word),
    .wr_src    (wr_src),
    .fifo_cnt  (fifo_cnt),
    .fifo_full (fifo_full),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef IRB_SRC_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .src_cnt   (src_cnt)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic irb_entry_t rand_entry();
    irb_entry_t e;
    e.src  = N'($urandom);
    e.addr = BADDR'($urandom);
    e.word = {$urandom, $urandom};
    return e;
  endfunction

  // Drive one cycle of inputs, advance one clock, then update the model from
  // the queue rules. Outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input irb_entry_t e, input logic busy,
                      input logic oclr, input logic rst);
    logic pop;
    logic push;
    recv_en   = en;
    recv_from = e.src;
    recv_addr = e.addr;
    recv_word = e.word;
    mem_busy  = busy;
    ovf_clr   = oclr;
    clr       = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_wr_en = 1'b0;
      m_wr    = '0;
      m_ovf   = 1'b0;
    end else begin
      pop  = (m_q.size() != 0) && !busy;
      push = en && ((m_q.size() < DEPTH) || pop);
      m_wr_en = pop;
      if (pop) m_wr = m_q.pop_front();
      if (push) m_q.push_back(e);
      if (en && !push) m_ovf = 1'b1;
      else if (oclr) m_ovf = 1'b0;
    end
  endtask

  task automatic idle(input logic busy);
    step(1'b0, '0, busy, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++;
    if ({wr_src, wr_addr, wr_word} !== '0) begin
      failures++; $display("FAIL reset_wr_data got=%h exp=0", {wr_src, wr_addr, wr_word});
    end
    checks++;
    if (fifo_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
    checks++;
    if (fifo_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    irb_entry_t e;
    e.src  = 8'b0000_0100;
    e.addr = 15'h0012;
    e.word = 64'hDEAD_BEEF;
    step(1'b1, e, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wr_en !== 1'b0 || fifo_cnt !== CW'(1)) begin
      failures++; $display("FAIL single_t1 got wr_en=%b cnt=%0d exp wr_en=0 cnt=1", wr_en, fifo_cnt);
    end
    idle(1'b0);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 15'h0012 || wr_word !== 64'hDEAD_BEEF || wr_src !== 8'b0000_0100) begin
      failures++;
      $display("FAIL single_t2 got en=%b addr=%h word=%h src=%b exp en=1 addr=0012 word=deadbeef src=00000100",
               wr_en, wr_addr, wr_word, wr_src);
    end
    checks++;
    if (fifo_cnt !== '0) begin failures++; $display("FAIL single_cnt got=%0d exp=0", fifo_cnt); end
    idle(1'b1);
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 15'h0012) begin
      failures++; $display("FAIL single_empty got en=%b addr=%h exp en=0 addr=0012", wr_en, wr_addr);
    end
    $display("test_single done");
  endtask

  task automatic test_backpressure();
    irb_entry_t sent[8];
    for (int i = 0; i < 8; i++) begin
      sent[i] = rand_entry();
      step(1'b1, sent[i], 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (fifo_full !== 1'b1 || fifo_cnt !== CW'(8) || ovf !== 1'b0) begin
      failures++; $display("FAIL bp_full got full=%b cnt=%0d ovf=%b exp 1 8 0", fifo_full, fifo_cnt, ovf);
    end
    step(1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
    checks++;
    if (ovf !== 1'b1 || fifo_cnt !== CW'(8)) begin
      failures++; $display("FAIL bp_drop got ovf=%b cnt=%0d exp ovf=1 cnt=8", ovf, fifo_cnt);
    end
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      idle(1'b0);
      checks++;
      if (wr_en !== 1'b1 || {wr_src, wr_addr, wr_word} !== sent[i] || ovf !== 1'b1) begin
        failures++;
        $display("FAIL bp_drain%0d got en=%b ent=%h ovf=%b exp en=1 ent=%h ovf=1",
                 i, wr_en, {wr_src, wr_addr, wr_word}, ovf, sent[i]);
      end
    end
    idle(1'b0);
    checks++;
    if (wr_en !== 1'b0 || ovf !== 1'b1) begin
      failures++; $display("FAIL bp_after got en=%b ovf=%b exp en=0 ovf=1", wr_en, ovf);
    end
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL bp_ovf_clr got=%b exp=0", ovf); end
    $display("test_backpressure done");
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) step(1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
    step(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_cnt !== CW'(8) || fifo_full !== 1'b1 || ovf !== 1'b0 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL fullpop got cnt=%0d full=%b ovf=%b en=%b exp 8 1 0 1", fifo_cnt, fifo_full, ovf, wr_en);
    end
    for (int i = 0; i < 9; i++) begin
      idle(1'b0);
      checks++;
      if (wr_en !== m_wr_en || {wr_src, wr_addr, wr_word} !== m_wr || fifo_cnt !== CW'(m_q.size())) begin
        failures++;
        $display("FAIL fullpop_drain%0d got en=%b ent=%h cnt=%0d exp en=%b ent=%h cnt=%0d",
                 i, wr_en, {wr_src, wr_addr, wr_word}, fifo_cnt, m_wr_en, m_wr, m_q.size());
      end
    end
    $display("test_full_pop done");
  endtask

  task automatic test_streaming();
    irb_entry_t sent[100];
    int writes;
    writes = 0;
    for (int k = 0; k < 101; k++) begin
      if (k < 100) begin
        sent[k] = rand_entry();
        step(1'b1, sent[k], 1'b0, 1'b0, 1'b0);
      end else begin
        idle(1'b0);
      end
      if (wr_en === 1'b1) writes++;
      checks++;
      if (k == 0) begin
        if (wr_en !== 1'b0) begin failures++; $display("FAIL stream_first got en=%b exp=0", wr_en); end
      end else if (wr_en !== 1'b1 || {wr_src, wr_addr, wr_word} !== sent[k-1]) begin
        failures++;
        $display("FAIL stream%0d got en=%b ent=%h exp en=1 ent=%h", k, wr_en, {wr_src, wr_addr, wr_word}, sent[k-1]);
      end
      checks++;
      if (fifo_cnt > CW'(1)) begin failures++; $display("FAIL stream_cnt%0d got=%0d exp<=1", k, fifo_cnt); end
    end
    idle(1'b0);
    checks++;
    if (wr_en !== 1'b0 || writes != 100) begin
      failures++; $display("FAIL stream_total got en=%b writes=%0d exp en=0 writes=100", wr_en, writes);
    end
    $display("test_streaming done writes=%0d", writes);
  endtask

  task automatic test_midreset();
    irb_entry_t e;
    for (int i = 0; i < 5; i++) step(1'b1, rand_entry(), 1'b1, 1'b0, 1'b0);
    checks++;
    if (fifo_cnt !== CW'(5)) begin failures++; $display("FAIL mid_fill got=%0d exp=5", fifo_cnt); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (fifo_cnt !== '0 || wr_en !== 1'b0 || fifo_full !== 1'b0) begin
      failures++; $display("FAIL mid_clr got cnt=%0d en=%b full=%b exp 0 0 0", fifo_cnt, wr_en, fifo_full);
    end
    idle(1'b0);
    checks++;
    if (wr_en !== 1'b0) begin failures++; $display("FAIL mid_noflush got en=%b exp=0", wr_en); end
    e = rand_entry();
    step(1'b1, e, 1'b0, 1'b0, 1'b0);
    checks++;
    if (wr_en !== 1'b0) begin failures++; $display("FAIL mid_new_t1 got en=%b exp=0", wr_en); end
    idle(1'b0);
    checks++;
    if (wr_en !== 1'b1 || {wr_src, wr_addr, wr_word} !== e) begin
      failures++; $display("FAIL mid_new_t2 got en=%b ent=%h exp en=1 ent=%h", wr_en, {wr_src, wr_addr, wr_word}, e);
    end
    $display("test_midreset done");
  endtask

  task automatic test_random();
    logic en;
    logic busy;
    logic oclr;
    logic rst;
    for (int k = 0; k < 400; k++) begin
      en   = ($urandom_range(0, 9) < 7);
      busy = ($urandom_range(0, 9) < 4);
      oclr = ($urandom_range(0, 19) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      step(en, rand_entry(), busy, oclr, rst);
      checks++;
      if ({wr_en, wr_src, wr_addr, wr_word, fifo_cnt, fifo_full, ovf} !==
          {m_wr_en, m_wr, CW'(m_q.size()), (m_q.size() == DEPTH), m_ovf}) begin
        failures++;
        $display("FAIL random%0d got en=%b ent=%h cnt=%0d full=%b ovf=%b exp en=%b ent=%h cnt=%0d full=%b ovf=%b",
                 k, wr_en, {wr_src, wr_addr, wr_word}, fifo_cnt, fifo_full, ovf,
                 m_wr_en, m_wr, m_q.size(), (m_q.size() == DEPTH), m_ovf);
      end
    end
    for (int k = 0; k < 10; k++) idle(1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    $display("test_random done");
  endtask

`ifdef IRB_SRC_CNT_EN
  task automatic test_src_cnt();
    irb_entry_t e;
    int exp_cnt[N];
    cnt_clr = 1'b1;
    idle(1'b0);
    cnt_clr = 1'b0;
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    for (int i = 0; i < 5; i++) begin
      e = rand_entry();
      e.src = (i < 3) ? 8'b0000_0010 : 8'b0100_0000;
      if (i < 3) exp_cnt[1]++; else exp_cnt[6]++;
      step(1'b1, e, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (src_cnt[i] !== 16'(exp_cnt[i])) begin
        failures++; $display("FAIL src_cnt%0d got=%0d exp=%0d", i, src_cnt[i], exp_cnt[i]);
      end
    end
    cnt_clr = 1'b1;
    idle(1'b0);
    cnt_clr = 1'b0;
    checks++;
    if (src_cnt !== '0) begin failures++; $display("FAIL src_cnt_clr got=%h exp=0", src_cnt); end
    $display("test_src_cnt done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop();
    test_streaming();
    test_midreset();
    test_random();
`ifdef IRB_SRC_CNT_EN
    test_src_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
